sad_lane_pipe: RTL and testbench

- Parametrised, pipelined successor to the 16-lane frame/window subtractor array.
- Computes per-lane frame-minus-window differences, in signed or absolute mode, for LANES pixels per beat.
- Reduces each beat to a row sum and accumulates ROWS beats into a block SAD.
- Tracks the minimum block sum and its index across a search, for the motion-estimation datapath.

---
 rtl/sad_lane_pipe.sv | 166 ++++++++++++++++
 tb/tb_sad_lane_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_lane_pipe.sv
// sad_lane_pipe: pipelined frame/window difference array with row reduction,
// block SAD accumulation and running-minimum tracking for motion estimation.
//
// Ports
//   Clk         clock, all logic on the rising edge
//   Reset       synchronous active-high reset, clears every register and output
//   start       one-cycle pulse opening a new search (clears accumulation,
//               block index, minimum tracker and in-flight beats)
//   in_valid    a frame/window beat is present on in_f/in_w
//   abs_mode    per-beat mode: 1 = |f-w|, 0 = signed f-w
//   in_f, in_w  LANES unsigned pixels, lane k at [k*IN_W +: IN_W]
//   diff_valid  diff_out carries the differences of a beat
//   diff_out    LANES signed differences, lane k at [k*DIFF_W +: DIFF_W]
//   blk_valid   one-cycle pulse, blk_sum/blk_idx hold a completed block
//   blk_sum     sum of all lane differences over ROWS beats
//   blk_idx     index of the completed block since start
//   min_valid   at least one block has completed since start/Reset
//   min_sum     smallest blk_sum so far (signed), min_idx its block index
module sad_lane_pipe #(
  parameter int LANES  = 16,
  parameter int IN_W   = 9,
  parameter int DIFF_W = 14,
  parameter int ROWS   = 16,
  parameter int SUM_W  = 24
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic                    abs_mode,
  input  logic [LANES*IN_W-1:0]   in_f,
  input  logic [LANES*IN_W-1:0]   in_w,
  output logic                    diff_valid,
  output logic [LANES*DIFF_W-1:0] diff_out,
  output logic                    blk_valid,
  output logic [SUM_W-1:0]        blk_sum,
  output logic [15:0]             blk_idx,
  output logic                    min_valid,
  output logic [SUM_W-1:0]        min_sum,
  output logic [15:0]             min_idx
);

  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

  // Zero-extended f minus w; in magnitude mode the negative results are
  // negated, which always fits because |f-w| <= 2^IN_W - 1.
  function automatic logic signed [DIFF_W-1:0] lane_diff(
    input logic [IN_W-1:0] f,
    input logic [IN_W-1:0] w,
    input logic            mag
  );
    logic signed [IN_W:0] d;
    d = $signed({1'b0, f}) - $signed({1'b0, w});
    if (mag && d[IN_W]) d = -d;
    return {{(DIFF_W-IN_W){d[IN_W]}}, d[IN_W-1:0]};
  endfunction

  // Signed sum of all lanes of one beat, wrapping modulo 2^SUM_W.
  function automatic logic signed [SUM_W-1:0] row_total(
    input logic [LANES*DIFF_W-1:0] v
  );
    logic signed [SUM_W-1:0]  s;
    logic signed [DIFF_W-1:0] l;
    s = '0;
    for (int k = 0; k < LANES; k++) begin
      l = v[k*DIFF_W +: DIFF_W];
      s = s + {{(SUM_W-DIFF_W){l[DIFF_W-1]}}, l};
    end
    return s;
  endfunction

  logic [LANES*DIFF_W-1:0] diff_p0_d;
  logic                    vld_p1_q;
  logic [LANES*DIFF_W-1:0] diff_p1_q;
  logic                    vld_p2_q;
  logic signed [SUM_W-1:0] row_p2_q;
  logic signed [SUM_W-1:0] acc_q;
  logic signed [SUM_W-1:0] blk_total_d;
  logic [CNT_W-1:0]        row_cnt_q;
  logic [15:0]             idx_q;
  logic                    blk_vld_q;
  logic signed [SUM_W-1:0] blk_sum_q;
  logic [15:0]             blk_idx_q;
  logic                    min_vld_q;
  logic signed [SUM_W-1:0] min_sum_q;
  logic [15:0]             min_idx_q;

  always_comb begin
    diff_p0_d = '0;
    for (int k = 0; k < LANES; k++) begin
      diff_p0_d[k*DIFF_W +: DIFF_W] =
        lane_diff(in_f[k*IN_W +: IN_W], in_w[k*IN_W +: IN_W], abs_mode);
    end
  end

  assign blk_total_d = acc_q + row_p2_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p1_q  <= 1'b0;
      diff_p1_q <= '0;
      vld_p2_q  <= 1'b0;
      row_p2_q  <= '0;
      acc_q     <= '0;
      row_cnt_q <= '0;
      idx_q     <= '0;
      blk_vld_q <= 1'b0;
      blk_sum_q <= '0;
      blk_idx_q <= '0;
      min_vld_q <= 1'b0;
      min_sum_q <= '0;
      min_idx_q <= '0;
    end else begin
      // Stage 1: per-lane differences. A beat arriving with start is row 0
      // of the new search, so start does not gate this stage.
      vld_p1_q <= in_valid;
      if (in_valid) diff_p1_q <= diff_p0_d;

      // Stage 2: row reduction. start drops the beat currently in stage 1.
      vld_p2_q <= vld_p1_q && !start;
      if (vld_p1_q) row_p2_q <= row_total(diff_p1_q);

      // Stage 3: block accumulation and minimum tracking. The minimum is
      // updated on the same edge that raises blk_valid, so during the pulse
      // min_* already include the completed block.
      blk_vld_q <= 1'b0;
      if (start) begin
        acc_q     <= '0;
        row_cnt_q <= '0;
        idx_q     <= '0;
        min_vld_q <= 1'b0;
        min_sum_q <= '0;
        min_idx_q <= '0;
      end else if (vld_p2_q) begin
        if (row_cnt_q == LAST_ROW) begin
          acc_q     <= '0;
          row_cnt_q <= '0;
          blk_vld_q <= 1'b1;
          blk_sum_q <= blk_total_d;
          blk_idx_q <= idx_q;
          idx_q     <= idx_q + 16'd1;
          // Strict compare: ties keep the earlier block.
          if (!min_vld_q || (blk_total_d < min_sum_q)) begin
            min_vld_q <= 1'b1;
            min_sum_q <= blk_total_d;
            min_idx_q <= idx_q;
          end
        end else begin
          acc_q     <= blk_total_d;
          row_cnt_q <= row_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign diff_valid = vld_p1_q;
  assign diff_out   = diff_p1_q;
  assign blk_valid  = blk_vld_q;
  assign blk_sum    = blk_sum_q;
  assign blk_idx    = blk_idx_q;
  assign min_valid  = min_vld_q;
  assign min_sum    = min_sum_q;
  assign min_idx    = min_idx_q;

endmodule

// File: tb/tb_sad_lane_pipe.sv
// Testbench for sad_lane_pipe: directed scenarios with literal expectations
// plus randomized traffic, checked every cycle against a reference model.
module tb_sad_lane_pipe;

  localparam int LANES  = 16;
  localparam int IN_W   = 9;
  localparam int DIFF_W = 14;
  localparam int ROWS   = 16;
  localparam int SUM_W  = 24;
  localparam int FW     = LANES*IN_W;
  localparam int DW     = LANES*DIFF_W;
  localparam int PMAX   = (1 << IN_W) - 1;

  logic             Clk;
  logic             Reset;
  logic             start;
  logic             in_valid;
  logic             abs_mode;
  logic [FW-1:0]    in_f;
  logic [FW-1:0]    in_w;
  logic             diff_valid;
  logic [DW-1:0]    diff_out;
  logic             blk_valid;
  logic [SUM_W-1:0] blk_sum;
  logic [15:0]      blk_idx;
  logic             min_valid;
  logic [SUM_W-1:0] min_sum;
  logic [15:0]      min_idx;

  sad_lane_pipe #(
    .LANES(LANES), .IN_W(IN_W), .DIFF_W(DIFF_W), .ROWS(ROWS), .SUM_W(SUM_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .in_valid(in_valid),
    .abs_mode(abs_mode), .in_f(in_f), .in_w(in_w),
    .diff_valid(diff_valid), .diff_out(diff_out),
    .blk_valid(blk_valid), .blk_sum(blk_sum), .blk_idx(blk_idx),
    .min_valid(min_valid), .min_sum(min_sum), .min_idx(min_idx)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk;
  int n_fail;
  bit chk_en;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  // Beats are held in a queue tagged with the edge that sampled them; a beat
  // contributes to the search two edges later, and a start discards every
  // beat still waiting. Expected outputs describe the state after each edge.
  typedef struct {
    int                      c;
    logic signed [SUM_W-1:0] rs;
  } beat_t;

  beat_t                   pend[$];
  int                      m_n;
  bit                      m_dv;
  logic [DW-1:0]           m_diff;
  bit                      m_bv;
  logic signed [SUM_W-1:0] m_bsum;
  logic [15:0]             m_bidx;
  bit                      m_mv;
  logic signed [SUM_W-1:0] m_msum;
  logic [15:0]             m_midx;
  logic signed [SUM_W-1:0] m_acc;
  int                      m_rows;
  logic [15:0]             m_idx;

  task automatic model_edge(input bit rst, input bit st, input bit iv, input bit am,
                            input logic [FW-1:0] f, input logic [FW-1:0] w);
    int    s, a, b, d;
    beat_t bt;
    m_n++;
    if (rst) begin
      m_dv = 0; m_diff = '0; m_bv = 0; m_bsum = '0; m_bidx = '0;
      m_mv = 0; m_msum = '0; m_midx = '0; m_acc = '0; m_rows = 0; m_idx = '0;
      pend.delete();
      return;
    end
    m_bv = 0;
    if (st) begin
      m_acc = '0; m_rows = 0; m_idx = '0; m_mv = 0; m_msum = '0; m_midx = '0;
      pend.delete();
    end else if (pend.size() > 0 && pend[0].c == m_n - 2) begin
      bt = pend.pop_front();
      m_acc = m_acc + bt.rs;
      m_rows++;
      if (m_rows == ROWS) begin
        m_bv   = 1;
        m_bsum = m_acc;
        m_bidx = m_idx;
        if (!m_mv || m_acc < m_msum) begin
          m_mv = 1; m_msum = m_acc; m_midx = m_idx;
        end
        m_idx++;
        m_acc  = '0;
        m_rows = 0;
      end
    end
    m_dv = iv;
    if (iv) begin
      s = 0;
      for (int k = 0; k < LANES; k++) begin
        a = int'(f[k*IN_W +: IN_W]);
        b = int'(w[k*IN_W +: IN_W]);
        d = a - b;
        if (am && d < 0) d = -d;
        m_diff[k*DIFF_W +: DIFF_W] = DIFF_W'(d);
        s += d;
      end
      bt.c  = m_n;
      bt.rs = SUM_W'(s);
      pend.push_back(bt);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic [SUM_W-1:0] lg_sum[$];
  logic [15:0]      lg_idx[$];
  int               lg_cyc[$];

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("diff_valid", diff_valid, m_dv);
      chk("diff_out", diff_out, m_diff);
      chk("blk_valid", blk_valid, m_bv);
      if (m_bv) begin
        chk("blk_sum", blk_sum, $unsigned(m_bsum));
        chk("blk_idx", blk_idx, m_bidx);
      end
      chk("min_valid", min_valid, m_mv);
      chk("min_sum", min_sum, $unsigned(m_msum));
      chk("min_idx", min_idx, m_midx);
      if (blk_valid === 1'b1) begin
        lg_sum.push_back(blk_sum);
        lg_idx.push_back(blk_idx);
        lg_cyc.push_back(m_n);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit rst, input bit st, input bit iv, input bit am,
                       input logic [FW-1:0] f, input logic [FW-1:0] w);
    Reset = rst; start = st; in_valid = iv; abs_mode = am; in_f = f; in_w = w;
    @(posedge Clk);
    model_edge(rst, st, iv, am, f, w);
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, '0, '0);
  endtask

  function automatic logic [FW-1:0] fill(input int v);
    logic [FW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*IN_W +: IN_W] = IN_W'(v);
    return r;
  endfunction

  function automatic logic [FW-1:0] rvec();
    logic [FW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*IN_W +: IN_W] = IN_W'($urandom_range(0, PMAX));
    return r;
  endfunction

  // Every lane gets f-w = d (or -d per lane when flip is set) on random pixels.
  task automatic uni(input int d, input bit flip, output logic [FW-1:0] f,
                     output logic [FW-1:0] w);
    int dd, lo, hi, wv;
    for (int k = 0; k < LANES; k++) begin
      dd = d;
      if (flip && $urandom_range(0, 1) == 1) dd = -d;
      lo = (dd < 0) ? -dd : 0;
      hi = PMAX - ((dd > 0) ? dd : 0);
      wv = lo + int'($urandom_range(0, hi - lo));
      f[k*IN_W +: IN_W] = IN_W'(wv + dd);
      w[k*IN_W +: IN_W] = IN_W'(wv);
    end
  endtask

  task automatic clr_log();
    lg_sum.delete(); lg_idx.delete(); lg_cyc.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [FW-1:0] f, w;
    int bc, b0, sc;
    n_chk = 0; n_fail = 0; chk_en = 0; m_n = 0;
    Reset = 1; start = 0; in_valid = 0; abs_mode = 0; in_f = '0; in_w = '0;
    drive(1, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 0, '0, '0);
    chk_en = 1;
    chk("rst_diff_valid", diff_valid, 1'b0);
    chk("rst_min_valid", min_valid, 1'b0);
    chk("rst_blk_idx", blk_idx, 16'd0);

    // Uniform abs block: 16 lanes * 16 rows * 7 = 1792.
    clr_log();
    for (int r = 0; r < ROWS; r++) begin
      drive(0, 0, 1, 1, fill(10), fill(3));
      if (r == 0) begin
        chk("s1_lane0", diff_out[0 +: DIFF_W], 14'd7);
        chk("s1_lane15", diff_out[15*DIFF_W +: DIFF_W], 14'd7);
      end
    end
    bc = m_n;
    idle(5);
    chk("s1_count", lg_sum.size(), 1);
    if (lg_sum.size() >= 1) begin
      chk("s1_sum", lg_sum[0], 24'd1792);
      chk("s1_idx", lg_idx[0], 16'd0);
      // in_valid in cycle 0 -> blk_valid in cycle 3, i.e. two edges later
      chk("s1_latency", lg_cyc[0], bc + 2);
    end
    chk("s1_min_valid", min_valid, 1'b1);
    chk("s1_min_sum", min_sum, 24'd1792);
    chk("s1_min_idx", min_idx, 16'd0);

    // Signed mode: lane0 0-511, other lanes equal -> -511 for the block.
    clr_log();
    f = rvec(); w = f;
    f[0 +: IN_W] = '0; w[0 +: IN_W] = IN_W'(511);
    drive(0, 0, 1, 0, f, w);
    chk("s2_lane0", diff_out[0 +: DIFF_W], 14'h3E01);
    for (int r = 1; r < ROWS; r++) begin
      f = rvec();
      drive(0, 0, 1, 0, f, f);
    end
    idle(5);
    chk("s2_count", lg_sum.size(), 1);
    if (lg_sum.size() >= 1) begin
      chk("s2_sum", lg_sum[0], 24'hFFFE01);
      chk("s2_idx", lg_idx[0], 16'd1);
    end
    chk("s2_min_sum", min_sum, 24'hFFFE01);
    chk("s2_min_idx", min_idx, 16'd1);

    // Three back-to-back blocks with lane magnitudes 5, 2, 2.
    clr_log();
    drive(0, 1, 0, 0, '0, '0);
    for (int b = 0; b < 3; b++) begin
      for (int r = 0; r < ROWS; r++) begin
        uni((b == 0) ? 5 : 2, 1, f, w);
        drive(0, 0, 1, 1, f, w);
      end
    end
    idle(5);
    chk("s3_count", lg_sum.size(), 3);
    if (lg_sum.size() >= 3) begin
      chk("s3_sum0", lg_sum[0], 24'd1280);
      chk("s3_sum1", lg_sum[1], 24'd512);
      chk("s3_sum2", lg_sum[2], 24'd512);
      chk("s3_idx2", lg_idx[2], 16'd2);
      chk("s3_gap01", lg_cyc[1] - lg_cyc[0], 16);
      chk("s3_gap12", lg_cyc[2] - lg_cyc[1], 16);
    end
    chk("s3_min_sum", min_sum, 24'd512);
    chk("s3_min_idx", min_idx, 16'd1);

    // Four idle cycles after row 7: same sum, pulse four cycles later.
    clr_log();
    drive(0, 1, 0, 0, '0, '0);
    b0 = 0;
    for (int r = 0; r < ROWS; r++) begin
      uni(-3, 0, f, w);
      drive(0, 0, 1, 0, f, w);
      if (r == 0) b0 = m_n;
      if (r == 7) idle(4);
    end
    idle(5);
    chk("s4_count", lg_sum.size(), 1);
    if (lg_sum.size() >= 1) begin
      chk("s4_sum", lg_sum[0], 24'hFFFD00);
      chk("s4_time", lg_cyc[0], b0 + 15 + 4 + 2);
    end

    // start with a beat after row 9: partial block is dropped.
    clr_log();
    for (int r = 0; r < 10; r++) begin
      uni(1, 1, f, w);
      drive(0, 0, 1, 1, f, w);
    end
    uni(1, 1, f, w);
    drive(0, 1, 1, 1, f, w);
    sc = m_n;
    chk("s5_min_cleared", min_valid, 1'b0);
    for (int r = 1; r < ROWS; r++) begin
      uni(1, 1, f, w);
      drive(0, 0, 1, 1, f, w);
    end
    idle(5);
    chk("s5_count", lg_sum.size(), 1);
    if (lg_sum.size() >= 1) begin
      chk("s5_sum", lg_sum[0], 24'd256);
      chk("s5_idx", lg_idx[0], 16'd0);
      chk("s5_time", lg_cyc[0], sc + 17);
    end

    // Reset mid-block while diff_valid is high.
    for (int r = 0; r < 5; r++) drive(0, 0, 1, 1, rvec(), rvec());
    chk("s6_dv_before", diff_valid, 1'b1);
    drive(1, 0, 1, 1, rvec(), rvec());
    chk("s6_dv", diff_valid, 1'b0);
    chk("s6_diff", diff_out, {DW{1'b0}});
    chk("s6_bv", blk_valid, 1'b0);
    chk("s6_bsum", blk_sum, {SUM_W{1'b0}});
    chk("s6_bidx", blk_idx, 16'd0);
    chk("s6_mv", min_valid, 1'b0);
    chk("s6_msum", min_sum, {SUM_W{1'b0}});
    chk("s6_midx", min_idx, 16'd0);
    clr_log();
    for (int r = 0; r < ROWS; r++) drive(0, 0, 1, $urandom_range(0, 1), rvec(), rvec());
    idle(5);
    chk("s6_count", lg_sum.size(), 1);
    if (lg_idx.size() >= 1) chk("s6_idx", lg_idx[0], 16'd0);

    // Randomized traffic: gaps, mixed modes, occasional start and Reset.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 499) == 0, $urandom_range(0, 199) == 0,
            $urandom_range(0, 9) < 8, $urandom_range(0, 1), rvec(), rvec());
    end
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
